// File: rtl/dsp48_pair_arbiter_if.sv
// Bus bundle between the requesters, the DSP48A1 pair and the pair arbiter.
// master: requester/DSP side; slave: arbiter side.
interface dsp48_pair_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 3
);
  localparam int unsigned OP_W = 92;
  localparam int unsigned P_W  = 48;

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic [OP_W*NREQ-1:0] req_ins_flat_l;
  logic [OP_W*NREQ-1:0] req_ins_flat_r;
  logic [OP_W-1:0]      dsp_ins_flat_l;
  logic [OP_W-1:0]      dsp_ins_flat_r;
  logic [P_W-1:0]       dsp_outs_flat_l;
  logic [P_W-1:0]       dsp_outs_flat_r;
  logic [P_W-1:0]       req_outs_flat_l;
  logic [P_W-1:0]       req_outs_flat_r;
  logic                 busy;
  logic [IDX_W-1:0]     owner;
  logic                 burst_err;

  modport master (
    output req, req_ins_flat_l, req_ins_flat_r, dsp_outs_flat_l, dsp_outs_flat_r,
    input  gnt, dsp_ins_flat_l, dsp_ins_flat_r, req_outs_flat_l, req_outs_flat_r,
    input  busy, owner, burst_err
  );

  modport slave (
    input  req, req_ins_flat_l, req_ins_flat_r, dsp_outs_flat_l, dsp_outs_flat_r,
    output gnt, dsp_ins_flat_l, dsp_ins_flat_r, req_outs_flat_l, req_outs_flat_r,
    output busy, owner, burst_err
  );
endinterface

// File: rtl/dsp48_pair_arbiter.sv
// Round-robin burst arbiter sharing one left/right DSP48A1 pair between NREQ
// sequencers, with a NOP drain gap after every release.
module dsp48_pair_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned GAP       = 2,
  parameter int unsigned MAX_BURST = 0,
  parameter int unsigned IDX_W     = 3
) (
  input logic                 clk,
  input logic                 reset,
  dsp48_pair_arbiter_if.slave bus
);
  localparam int unsigned OP_W       = 92;
  localparam int unsigned GAP_W      = 4;
  localparam int unsigned BC_W       = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned BURST_LAST = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;

  state_t           state_q, state_n;
  logic [NREQ-1:0]  gnt_q, gnt_n;
  logic [IDX_W-1:0] owner_q, owner_n;
  logic [IDX_W-1:0] rr_q, rr_n;
  logic [BC_W-1:0]  bc_q, bc_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             err_q, err_n;
  logic             busy_q, busy_n;

  logic [2*NREQ-1:0] req_dbl;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic              own_req;
  logic              revoke;
  logic [OP_W-1:0]   own_l, own_r;

  function automatic logic [IDX_W-1:0] idx_wrap(input logic [31:0] v);
    return (v >= NREQ) ? IDX_W'(v - NREQ) : IDX_W'(v);
  endfunction

  // Round-robin scan: rotate req so bit 0 is the requester at rr.
  always_comb begin
    req_dbl    = {bus.req, bus.req} >> rr_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_found && req_dbl[i]) begin
        pick_found = 1'b1;
        pick_idx   = idx_wrap(32'(rr_q) + i);
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      pick_oh[k] = (pick_idx == IDX_W'(k));
    end
  end

  // Owner's request bit and bus slices.
  always_comb begin
    own_req = 1'b0;
    own_l   = '0;
    own_r   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_req = bus.req[k];
        own_l   = bus.req_ins_flat_l[k*OP_W +: OP_W];
        own_r   = bus.req_ins_flat_r[k*OP_W +: OP_W];
      end
    end
  end

  assign revoke = (MAX_BURST != 0) && (bc_q == BC_W'(BURST_LAST)) && own_req;

  // Next-state and next registered outputs.
  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    owner_n = owner_q;
    rr_n    = rr_q;
    bc_n    = bc_q;
    gap_n   = gap_q;
    err_n   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_n = ST_GRANT;
          gnt_n   = pick_oh;
          owner_n = pick_idx;
          rr_n    = idx_wrap(32'(pick_idx) + 32'd1);
          bc_n    = '0;
        end
      end
      ST_GRANT: begin
        bc_n = bc_q + BC_W'(1);
        if (!own_req || revoke) begin
          gnt_n = '0;
          err_n = revoke;
          if (GAP == 0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DRAIN;
            gap_n   = GAP_W'(GAP);
          end
        end
      end
      ST_DRAIN: begin
        gap_n = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      bc_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      owner_q <= owner_n;
      rr_q    <= rr_n;
      bc_q    <= bc_n;
      gap_q   <= gap_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  // Slices see NOPs whenever nobody owns them.
  assign bus.dsp_ins_flat_l  = (state_q == ST_GRANT) ? own_l : '0;
  assign bus.dsp_ins_flat_r  = (state_q == ST_GRANT) ? own_r : '0;
  assign bus.req_outs_flat_l = bus.dsp_outs_flat_l;
  assign bus.req_outs_flat_r = bus.dsp_outs_flat_r;
  assign bus.gnt             = gnt_q;
  assign bus.owner           = owner_q;
  assign bus.busy            = busy_q;
  assign bus.burst_err       = err_q;
endmodule

// File: tb/tb_dsp48_pair_arbiter.sv
// Randomized bench for dsp48_pair_arbiter: four builds share one stimulus and
// each is checked every cycle against a burst/rotation reference model.
module tb_dsp48_pair_arbiter;
  localparam logic [91:0] SL0 = {8'h01, 18'd5, 18'd3, 48'd0};
  localparam logic [91:0] SR0 = {8'h02, 18'd7, 18'd9, 48'd11};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   req_s = '0;
  logic [367:0] ins_l = '0;
  logic [367:0] ins_r = '0;
  logic [47:0]  pl = '0;
  logic [47:0]  pr = '0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           g0_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string nm, input logic [91:0] act,
                     input logic [91:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL c%0d %s @cycle %0d: got %h, expected %h", id, nm, cyc, act, exp);
    end
  endtask

  for (genvar c = 0; c < 4; c++) begin : cfg
    localparam int N  = (c == 3) ? 3 : 4;
    localparam int IW = (c == 3) ? 2 : 3;
    localparam int G  = (c == 1) ? 0 : (c == 3) ? 1 : 2;
    localparam int M  = (c == 2) ? 4 : (c == 3) ? 1 : 0;

    dsp48_pair_arbiter_if #(.NREQ(N), .IDX_W(IW)) bus ();

    assign bus.req             = req_s[N-1:0];
    assign bus.req_ins_flat_l  = ins_l[92*N-1:0];
    assign bus.req_ins_flat_r  = ins_r[92*N-1:0];
    assign bus.dsp_outs_flat_l = pl;
    assign bus.dsp_outs_flat_r = pr;

    dsp48_pair_arbiter #(.NREQ(N), .GAP(G), .MAX_BURST(M), .IDX_W(IW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    // Model: holder = current grantee or -1, nop = drain cycles still owed.
    int holder = -1;
    int ptr = 0;
    int gcnt = 0;
    int nop = 0;
    int last = 0;
    bit err = 1'b0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        holder = -1; ptr = 0; gcnt = 0; nop = 0; last = 0; err = 1'b0;
      end else begin
        err = 1'b0;
        if (holder >= 0) begin
          gcnt++;
          if (!req_s[holder]) begin
            holder = -1; nop = G;
          end else if (M != 0 && gcnt == M) begin
            holder = -1; nop = G; err = 1'b1;
          end
        end else if (nop > 0) begin
          nop--;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (holder < 0 && req_s[(ptr + i) % N]) holder = (ptr + i) % N;
          end
          if (holder >= 0) begin
            last = holder; ptr = (holder + 1) % N; gcnt = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      logic [7:0]  exp_gnt;
      logic [91:0] exp_l, exp_r;
      if (cyc >= 1) begin
        exp_gnt = (holder >= 0) ? (8'd1 << holder) : 8'd0;
        exp_l   = (holder >= 0) ? ins_l[92*holder +: 92] : '0;
        exp_r   = (holder >= 0) ? ins_r[92*holder +: 92] : '0;
        chk(c, "gnt",       92'(bus.gnt),             92'(exp_gnt));
        chk(c, "busy",      92'(bus.busy),            92'(holder >= 0 || nop > 0));
        chk(c, "owner",     92'(bus.owner),           92'(last));
        chk(c, "burst_err", 92'(bus.burst_err),       92'(err));
        chk(c, "dsp_l",     bus.dsp_ins_flat_l,       exp_l);
        chk(c, "dsp_r",     bus.dsp_ins_flat_r,       exp_r);
        chk(c, "pout_l",    92'(bus.req_outs_flat_l), 92'(pl));
        chk(c, "pout_r",    92'(bus.req_outs_flat_r), 92'(pr));
      end
    end
  end

  // Hand-computed expectations for the directed opening sequence.
  always @(negedge clk) begin
    if (cyc < 40 && cfg[0].bus.gnt[0]) g0_cnt++;
    case (cyc)
      10: chk(0, "lit_latency", 92'(cfg[0].bus.gnt), 92'(0));
      11: begin
        chk(0, "lit_gnt_first", 92'(cfg[0].bus.gnt), 92'(1));
        chk(0, "lit_dsp_l", cfg[0].bus.dsp_ins_flat_l, SL0);
        chk(0, "lit_dsp_r", cfg[0].bus.dsp_ins_flat_r, SR0);
      end
      14: chk(2, "lit_gnt_burst_end", 92'(cfg[2].bus.gnt), 92'(1));
      15: begin
        chk(2, "lit_revoke_err", 92'(cfg[2].bus.burst_err), 92'(1));
        chk(2, "lit_revoke_gnt", 92'(cfg[2].bus.gnt), 92'(0));
      end
      16: chk(2, "lit_err_pulse", 92'(cfg[2].bus.burst_err), 92'(0));
      18: begin
        chk(0, "lit_gnt_last", 92'(cfg[0].bus.gnt), 92'(1));
        chk(2, "lit_regrant", 92'(cfg[2].bus.gnt), 92'(1));
      end
      19: begin
        chk(0, "lit_gnt_off", 92'(cfg[0].bus.gnt), 92'(0));
        chk(0, "lit_drain_nop", cfg[0].bus.dsp_ins_flat_l, 92'(0));
        chk(0, "lit_drain_busy", 92'(cfg[0].bus.busy), 92'(1));
        chk(1, "lit_gap0_idle", 92'(cfg[1].bus.busy), 92'(0));
      end
      20: chk(0, "lit_drain2_busy", 92'(cfg[0].bus.busy), 92'(1));
      21: begin
        chk(0, "lit_idle_busy", 92'(cfg[0].bus.busy), 92'(0));
        chk(0, "lit_owner_held", 92'(cfg[0].bus.owner), 92'(0));
      end
      40: chk(0, "lit_burst_len", 92'(g0_cnt), 92'(8));
      default: ;
    endcase
  end

  task automatic rand_ins();
    for (int s = 0; s < 4; s++) begin
      ins_l[92*s +: 92] = 92'({$urandom(), $urandom(), $urandom()});
      ins_r[92*s +: 92] = 92'({$urandom(), $urandom(), $urandom()});
    end
    pl = 48'({$urandom(), $urandom()});
    pr = 48'({$urandom(), $urandom()});
  endtask

  task automatic rand_req();
    for (int b = 0; b < 4; b++) begin
      if (req_s[b]) begin
        if ($urandom_range(9) == 0) req_s[b] = 1'b0;
      end else if ($urandom_range(4) == 0) begin
        req_s[b] = 1'b1;
      end
    end
  endtask

  initial begin
    bit seen;
    ins_l = '1;
    ins_r = '1;
    ins_l[91:0] = SL0;
    ins_r[91:0] = SR0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Directed: requester 0 alone for cycles 10..17, others drive FF/3FFFF noise.
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      req_s = (cyc >= 10 && cyc <= 17) ? 8'h01 : 8'h00;
      pl = 48'($urandom());
      pr = 48'($urandom());
    end

    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      rand_req();
      rand_ins();
    end

    // Asynchronous reset in the third cycle of a burst.
    @(posedge clk);
    #1 req_s = 8'h04;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (cfg[0].bus.gnt[2]) seen = 1'b1;
    end
    chk(0, "rst_setup_gnt2_seen", 92'(seen), 92'(1));
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk(0, "rst_gnt", 92'(cfg[0].bus.gnt), 92'(0));
    chk(0, "rst_busy", 92'(cfg[0].bus.busy), 92'(0));
    chk(0, "rst_owner", 92'(cfg[0].bus.owner), 92'(0));
    chk(0, "rst_dsp_l", cfg[0].bus.dsp_ins_flat_l, 92'(0));
    req_s = 8'h0C;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk(0, "rst_regrant_rr0", 92'(cfg[0].bus.gnt), 92'(4));
    chk(0, "rst_regrant_owner", 92'(cfg[0].bus.owner), 92'(2));

    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      rand_req();
      rand_ins();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
